// File: rtl/mbox_pkg.sv
// Shared constants for the AHB mailbox: register offsets, FSM states, STATUS fields.
package mbox_pkg;

  localparam int unsigned OFF_HALT   = 32'h00;
  localparam int unsigned OFF_PUTC   = 32'h04;
  localparam int unsigned OFF_CYC_LO = 32'h08;
  localparam int unsigned OFF_CYC_HI = 32'h0C;
  localparam int unsigned OFF_STATUS = 32'h10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  localparam int unsigned STAT_USED_LSB = 0;
  localparam int unsigned STAT_FREE_LSB = 8;
  localparam int unsigned STAT_FIELD_W  = 8;

  localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/mbox_fifo.sv
// Power-of-two character FIFO with valid/ready style push/pop and occupancy count.
module mbox_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only allowed when a pop frees the slot this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ahb_mbox.sv
// AHB-Lite simulation mailbox: HALT/PUTC sinks, 64-bit cycle counter with
// coherent hi/lo reads, and FIFO status.
module ahb_mbox
  import mbox_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic [31:0]       hrdata,
  output logic              hresp,
  output logic              putc_valid,
  output logic [7:0]        putc_data,
  input  logic              putc_ready,
  output logic              halt,
  output logic [31:0]       halt_code
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       state_q, state_d;
  logic             dph_q, dph_d;
  logic             dph_putc_q, dph_putc_d;
  logic [63:0]      cyc_q;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic             halt_q, halt_d;
  logic [31:0]      halt_code_q, halt_code_d;

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_data;

  logic             accept_c, legal_c, is_putc_c, is_cyc_lo_c;
  logic [31:0]      rvalue_c, status_c;
  logic             putc_pend_c, push_c, pop_c, stall_c, hreadyout_c;

  mbox_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .data_i  (hwdata[7:0]),
    .full_o  (fifo_full),
    .pop_i   (pop_c),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status_c = '0;
    status_c[STAT_FREE_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(FIFO_DEPTH) - STAT_FIELD_W'(fifo_count);
    status_c[STAT_USED_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(fifo_count);
  end

  // Address-phase decode: legality and read value are resolved before the data phase.
  always_comb begin
    legal_c     = 1'b0;
    rvalue_c    = '0;
    is_putc_c   = (haddr == ADDR_W'(OFF_PUTC));
    is_cyc_lo_c = (haddr == ADDR_W'(OFF_CYC_LO));
    if (haddr == ADDR_W'(OFF_HALT)) begin
      legal_c = hwrite && (hsize == HSIZE_WORD);
    end else if (is_putc_c) begin
      legal_c = hwrite && (hsize <= HSIZE_WORD);
    end else if (is_cyc_lo_c) begin
      legal_c  = !hwrite && (hsize == HSIZE_WORD);
      rvalue_c = cyc_q[31:0];
    end else if (haddr == ADDR_W'(OFF_CYC_HI)) begin
      legal_c  = !hwrite && (hsize == HSIZE_WORD);
      rvalue_c = shadow_q;
    end else if (haddr == ADDR_W'(OFF_STATUS)) begin
      legal_c  = !hwrite && (hsize == HSIZE_WORD);
      rvalue_c = status_c;
    end
  end

  assign pop_c       = !fifo_empty && putc_ready;
  assign putc_pend_c = ((state_q == ST_IDLE) && dph_q && dph_putc_q) || (state_q == ST_WAIT);
  assign push_c      = putc_pend_c && (!fifo_full || pop_c);
  assign stall_c     = putc_pend_c && !push_c;
  assign hreadyout_c = (state_q != ST_ERR1) && !stall_c;
  assign accept_c    = hsel && htrans[1] && hready && hreadyout_c;

  always_comb begin
    state_d     = state_q;
    dph_d       = 1'b0;
    dph_putc_d  = dph_putc_q;
    hrdata_d    = '0;
    shadow_d    = shadow_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;

    // HALT is sticky: only the first write lands.
    if ((state_q == ST_IDLE) && dph_q && !dph_putc_q && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = hwdata;
    end

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (stall_c)                   state_d = ST_WAIT;
        else if (accept_c && !legal_c) state_d = ST_ERR1;
        else                           state_d = ST_IDLE;
      end
    endcase

    if (accept_c && legal_c) begin
      dph_d      = hwrite;
      dph_putc_d = is_putc_c;
      if (!hwrite) hrdata_d = rvalue_c;
      if (!hwrite && is_cyc_lo_c) shadow_d = cyc_q[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dph_q       <= 1'b0;
      dph_putc_q  <= 1'b0;
      cyc_q       <= '0;
      shadow_q    <= '0;
      hrdata_q    <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      state_q     <= state_d;
      dph_q       <= dph_d;
      dph_putc_q  <= dph_putc_d;
      cyc_q       <= cyc_q + 64'd1;
      shadow_q    <= shadow_d;
      hrdata_q    <= hrdata_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign hreadyout  = hreadyout_c;
  assign hresp      = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign hrdata     = hrdata_q;
  assign putc_valid = !fifo_empty;
  assign putc_data  = fifo_data;
  assign halt       = halt_q;
  assign halt_code  = halt_code_q;

endmodule

// File: tb/tb_ahb_mbox.sv
// Directed bench for ahb_mbox: reset values, HALT, PUTC stall/stream, counter, errors.
module tb_ahb_mbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;
  logic        putc_valid;
  logic [7:0]  putc_data;
  logic        putc_ready;
  logic        halt;
  logic [31:0] halt_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_mbox #(.FIFO_DEPTH(8), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready     (hready),
    .hreadyout  (hreadyout),
    .hrdata     (hrdata),
    .hresp      (hresp),
    .putc_valid (putc_valid),
    .putc_data  (putc_data),
    .putc_ready (putc_ready),
    .halt       (halt),
    .halt_code  (halt_code)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Non-pipelined transfer; returns read data, first/final hresp and wait count.
  task automatic xfer(input logic [7:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic r1, output logic r2, output int waits);
    @(negedge clk);
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0;
    r1 = hresp;
    while (!hreadyout && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rd = hrdata;
    r2 = hresp;
  endtask

  task automatic wr_ok(input string tag, input logic [7:0] a, input logic [2:0] sz, input logic [31:0] d);
    logic [31:0] rd; logic r1, r2; int w;
    xfer(a, 1'b1, sz, d, rd, r1, r2, w);
    chk({tag, "_waits"}, 64'(w), 64'd0);
    chk({tag, "_resp"}, 64'(r2), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic r1, r2; int w;
    xfer(a, 1'b0, 3'd2, 32'h0, rd, r1, r2, w);
    chk({tag, "_data"}, 64'(rd), 64'(exp));
    chk({tag, "_resp"}, 64'(r2), 64'd0);
  endtask

  task automatic err_chk(input string tag, input logic [7:0] a, input logic w, input logic [2:0] sz);
    logic [31:0] rd; logic r1, r2; int waits;
    xfer(a, w, sz, 32'hDEAD_BEEF, rd, r1, r2, waits);
    chk({tag, "_c1resp"}, 64'(r1), 64'd1);
    chk({tag, "_waits"}, 64'(waits), 64'd1);
    chk({tag, "_c2resp"}, 64'(r2), 64'd1);
    chk({tag, "_rdata"}, 64'(rd), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] stream[6];
    logic [7:0] e;
    int guard;

    rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hwdata = '0; putc_ready = 1'b0;
    #12;
    chk("rst_hreadyout", 64'(hreadyout), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    chk("rst_putc_valid", 64'(putc_valid), 64'd0);
    chk("rst_putc_data", 64'(putc_data), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_halt_code", 64'(halt_code), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    rd_chk("status_reset", 8'h10, 32'h0000_0800);
    @(negedge clk);
    chk("hrdata_idle_zero", 64'(hrdata), 64'd0);

    // IDLE transfer while selected gets a zero-wait OKAY.
    hsel = 1'b1; htrans = 2'b00; haddr = 8'h14;
    @(negedge clk);
    chk("idle_hreadyout", 64'(hreadyout), 64'd1);
    chk("idle_hresp", 64'(hresp), 64'd0);
    hsel = 1'b0;

    wr_ok("halt0", 8'h00, 3'd2, 32'h0);
    @(negedge clk);
    chk("halt_set", 64'(halt), 64'd1);
    chk("halt_code0", 64'(halt_code), 64'd0);
    wr_ok("halt5", 8'h00, 3'd2, 32'h5);
    @(negedge clk);
    chk("halt_sticky", 64'(halt), 64'd1);
    chk("halt_code_kept", 64'(halt_code), 64'd0);

    err_chk("err_unmapped", 8'h14, 1'b0, 3'd2);
    err_chk("err_wr_ro", 8'h08, 1'b1, 3'd2);
    err_chk("err_rd_wo", 8'h00, 1'b0, 3'd2);
    err_chk("err_half_status", 8'h10, 1'b0, 3'd1);
    err_chk("err_putc_off5", 8'h05, 1'b1, 3'd0);
    err_chk("err_putc_read", 8'h04, 1'b0, 3'd2);
    rd_chk("status_after_err", 8'h10, 32'h0000_0800);
    chk("putc_valid_after_err", 64'(putc_valid), 64'd0);

    putc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_ok("putc_fill", 8'h04, 3'(i % 3), 32'h0000_0041 + 32'(i));
    end
    @(negedge clk);
    chk("fill_head", 64'(putc_data), 64'h41);
    hsel = 1'b1; haddr = 8'h04; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_0049;
    chk("full_stall1", 64'(hreadyout), 64'd0);
    @(negedge clk);
    chk("full_stall2", 64'(hreadyout), 64'd0);
    chk("stall_head_stable", 64'(putc_data), 64'h41);
    putc_ready = 1'b1;
    #1;
    chk("stall_release", 64'(hreadyout), 64'd1);
    @(negedge clk);
    putc_ready = 1'b0;
    chk("after_pop_head", 64'(putc_data), 64'h42);
    chk("after_pop_ready", 64'(hreadyout), 64'd1);
    rd_chk("status_full", 8'h10, 32'h0000_0008);

    // Full FIFO, consumer ready, back-to-back PUTC stream.
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h42 + 8'(i));
    for (int i = 0; i < 6; i++) stream[i] = 8'h61 + 8'(i);
    @(negedge clk);
    putc_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      chk("stream_ready", 64'(hreadyout), 64'd1);
      e = exp_q.pop_front();
      chk("stream_head", 64'(putc_data), 64'(e));
      if (i > 0) begin
        hwdata = 32'(stream[i-1]);
        exp_q.push_back(stream[i-1]);
      end
      if (i < 6) begin
        hsel = 1'b1; haddr = 8'h04; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd0;
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      @(negedge clk);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      e = exp_q.pop_front();
      chk("drain_head", 64'(putc_data), 64'(e));
      guard++;
      @(negedge clk);
    end
    chk("drain_empty", 64'(putc_valid), 64'd0);
    putc_ready = 1'b0;

    // Counter parked just below a 32-bit carry; hi must come from the snapshot.
    @(negedge clk);
    force dut.cyc_q = 64'h0000_0001_FFFF_FFFF;
    rd_chk("cyc_lo", 8'h08, 32'hFFFF_FFFF);
    release dut.cyc_q;
    rd_chk("cyc_hi_shadow", 8'h0C, 32'h0000_0001);
    rd_chk("cyc_hi_before_lo", 8'h0C, 32'h0000_0001);
    begin
      logic [31:0] rd; logic r1, r2; int w;
      xfer(8'h08, 1'b0, 3'd2, 32'h0, rd, r1, r2, w);
      chk("cyc_lo_after_carry_small", 64'(rd < 32'd100), 64'd1);
    end
    rd_chk("cyc_hi_carried", 8'h0C, 32'h0000_0002);

    // Reset in the middle of a full-FIFO stall.
    for (int i = 0; i < 8; i++) wr_ok("refill", 8'h04, 3'd2, 32'h30 + 32'(i));
    @(negedge clk);
    hsel = 1'b1; haddr = 8'h04; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h5A;
    chk("rst_stall_pre", 64'(hreadyout), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hreadyout", 64'(hreadyout), 64'd1);
    chk("midrst_putc_valid", 64'(putc_valid), 64'd0);
    chk("midrst_hresp", 64'(hresp), 64'd0);
    chk("midrst_halt", 64'(halt), 64'd0);
    chk("midrst_halt_code", 64'(halt_code), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("status_post_rst", 8'h10, 32'h0000_0800);
    chk("post_rst_putc_valid", 64'(putc_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_mbox.md
AHB_MBOX -- requirements
Module: ahb_mbox

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 8, which sets the PUTC character FIFO depth (a power of two, at least 2).
REQ-002 The module SHALL have parameter ADDR_W, default 8, which sets the width of the slave offset address.
REQ-003 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all flops on its rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- hsel, in, 1: slave select.
- haddr, in, ADDR_W: byte offset.
- htrans, in, 2: AHB-Lite transfer type.
- hwrite, in, 1: 1 = write.
- hsize, in, 3: transfer size.
- hwdata, in, 32: write data (data phase).
- hready, in, 1: bus ready.
- hreadyout, out, 1: slave ready.
- hrdata, out, 32: read data.
- hresp, out, 1: 1 = ERROR.
- putc_valid, out, 1: character available.
- putc_data, out, 8: FIFO head character.
- putc_ready, in, 1: host accepts the character.
- halt, out, 1: sticky halt request.
- halt_code, out, 32: exit code written to HALT.

Function
REQ-004 An address phase SHALL be accepted when hsel && htrans==NONSEQ && hready, and its haddr, hwrite and hsize SHALL be registered; the next cycle is the data phase. SEQ SHALL be treated as NONSEQ, and IDLE/BUSY SHALL get a zero-wait OKAY response.
REQ-005 Register map (word offsets):
- 0x00 HALT (write-only).
- 0x04 PUTC (write-only, byte [7:0] used).
- 0x08 CYC_LO (read-only).
- 0x0C CYC_HI (read-only).
- 0x10 STATUS (read-only): [15:8] free entries, [7:0] used entries.
REQ-006 Only hsize==word with haddr[1:0]==0 SHALL be legal for HALT, CYC_LO, CYC_HI and STATUS; PUTC SHALL accept byte, half and word sizes at offset 0x04.
REQ-007 Any illegal access SHALL receive a two-cycle ERROR response: cycle 1 hreadyout=0 with hresp=1, cycle 2 hreadyout=1 with hresp=1. Illegal accesses are: unmapped offset, write to a read-only register, read from a write-only register, or a misaligned/illegal size.
REQ-008 A HALT write SHALL set halt=1 and capture hwdata into halt_code in the data phase. halt SHALL stay set until reset; later HALT writes SHALL be ignored (OKAY, no update).
REQ-009 A PUTC write SHALL push hwdata[7:0] with zero wait states when the FIFO is not full.
REQ-010 When the FIFO is full, a PUTC write SHALL hold hreadyout=0 (WAIT state) and complete in the first cycle with a free entry. hwdata SHALL be sampled in the completing cycle.
REQ-011 The FSM states SHALL be IDLE, WAIT, ERR1, ERR2, with these transitions:
- IDLE to WAIT on a full-FIFO PUTC.
- IDLE to ERR1 on an illegal access.
- ERR1 to ERR2 unconditionally.
- WAIT to IDLE when a push completes.
- ERR2 to IDLE.
REQ-012 FIFO output SHALL use a valid/ready handshake. putc_valid = !empty; a pop SHALL occur on putc_valid && putc_ready; putc_data SHALL be stable while putc_valid && !putc_ready.
REQ-013 A simultaneous push and pop on a full FIFO SHALL complete the push with zero wait states, and the count SHALL stay unchanged.
REQ-014 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-015 The cycle counter SHALL be a 64-bit counter incrementing every cycle after reset and wrapping modulo 2^64.
REQ-016 A CYC_LO read SHALL return bits [31:0] and snapshot bits [63:32] into a shadow register; a CYC_HI read SHALL return that shadow.
REQ-017 hrdata SHALL be valid in the data phase only, and SHALL be 0 otherwise and on error.

Reset
REQ-018 While rst_n=0, the outputs SHALL be: hreadyout=1, hresp=0, hrdata=0, putc_valid=0, putc_data=0, halt=0, halt_code=0.
REQ-019 While rst_n=0, the internal state SHALL be: FSM=IDLE, FIFO empty, counter=0, shadow=0, no pending data phase.
REQ-020 A reset asserted mid-WAIT or mid-ERR SHALL abort the transfer, with no push and no halt.

Structure
REQ-021 Package mbox_pkg SHALL hold the register offset constants, the FSM state enum and the STATUS field positions.
REQ-022 The FIFO SHALL be a separate sub-module, mbox_fifo (parameters DEPTH, WIDTH), with push/full/pop/empty/count ports.
REQ-023 The address decode, FSM, counter and halt logic SHALL live in ahb_mbox.

Verification
REQ-024 Write word 0 to 0x00 -> next cycle halt=1, halt_code=0. A second write of 5 -> halt_code stays 0.
REQ-025 With putc_ready=0, write 'A'..'I' (9 bytes) to 0x04 -> 8 writes complete with zero wait; the 9th stalls with hreadyout=0. Raise putc_ready for 1 cycle -> 'A' pops and the 9th completes that cycle; STATUS reads 0x0008.
REQ-026 Read 0x08 at counter 0x1_FFFFFFFF then read 0x0C -> 0xFFFFFFFF then 0x00000001, even if the counter carries between the two reads.
REQ-027 Read 0x14, write 0x08, read 0x00, halfword read of 0x10 -> each gives hresp=1 for 2 cycles with hreadyout low then high; no state changes.
REQ-028 Pull rst_n low during a full-FIFO stall -> hreadyout=1 and putc_valid=0 immediately; after release, STATUS=0x0800.
REQ-029 Full FIFO with putc_ready=1 and a back-to-back PUTC stream -> no wait states and one character out per cycle, in order.
